// File: rtl/alu_cg_pkg.sv
// alu_cg_pkg: shared state encoding, ALU unit codes and sizing helpers for the clock gate controller
package alu_cg_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      GATED  = 2'd1,
      WAKE   = 2'd2
   } cg_state_t;

   localparam int UNIT_ADD   = 0;
   localparam int UNIT_LOGIC = 1;
   localparam int UNIT_SHIFT = 2;
   localparam int UNIT_MUL   = 3;

   localparam int DEF_NUM_DOM = 4;

   // Counter width that never collapses to zero bits for tiny parameter values
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cg_domain_fsm.sv
// cg_domain_fsm: one ALU domain's ACTIVE/GATED/WAKE controller with idle and wake counters
module cg_domain_fsm
   import alu_cg_pkg::*;
#(
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_req,
   input  logic i_accept,
   input  logic i_force,
   output logic o_active,
   output logic o_gate_en,
   output logic o_gated,
   output logic o_enter_gated
);

   localparam int IW = cnt_w(IDLE_CYCLES);
   localparam int WW = cnt_w(WAKE_CYCLES);

   cg_state_t       r_state;
   cg_state_t       w_next;
   logic [IW-1:0]   r_idle;
   logic [WW-1:0]   r_wake;
   logic            r_gate_en;
   logic            r_gated;
   logic            w_idle_inc;
   logic            w_expire;
   logic            w_wake_done;

   assign w_idle_inc    = (r_state == ACTIVE) && !i_accept && !i_force;
   assign w_expire      = w_idle_inc && (r_idle == IW'(IDLE_CYCLES - 1));
   assign w_wake_done   = (r_state == WAKE) && (r_wake == '0);
   assign o_active      = (r_state == ACTIVE);
   assign o_gate_en     = r_gate_en;
   assign o_gated       = r_gated;
   assign o_enter_gated = w_expire;

   // Next-state selection: gate on idle expiry, wake on a request or override, resume when settled
   always_comb begin
      w_next = (r_state == GATED) ? ((i_req || i_force) ? WAKE : GATED) :
               (r_state == WAKE)  ? (w_wake_done ? ACTIVE : WAKE) :
               (w_expire ? GATED : ACTIVE);
   end

   // State, counters and the registered enable/status outputs, reset taking priority over everything
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ACTIVE;
         r_idle    <= '0;
         r_wake    <= '0;
         r_gate_en <= 1'b1;
         r_gated   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_idle    <= w_idle_inc ? r_idle + 1'b1 : '0;
         r_wake    <= ((r_state == GATED) && (i_req || i_force)) ? WW'(WAKE_CYCLES - 1) :
                      ((r_state == WAKE) && !w_wake_done) ? r_wake - 1'b1 : '0;
         r_gate_en <= (w_next != GATED);
         r_gated   <= (w_next == GATED);
      end
   end

endmodule

// File: rtl/clock_gate_controller.sv
// clock_gate_controller: per-domain ALU clock enables with op admission and a saturating gate-event counter
module clock_gate_controller
   import alu_cg_pkg::*;
#(
   parameter int NUM_DOM     = DEF_NUM_DOM,
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        op_valid,
   input  logic [(NUM_DOM > 1 ? $clog2(NUM_DOM) : 1)-1:0] op_unit,
   output logic                                        op_ready,
   input  logic                                        force_on,
   output logic [NUM_DOM-1:0]                          gate_en,
   output logic [NUM_DOM-1:0]                          gated,
   output logic [15:0]                                 gate_count
);

   localparam int UW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

   logic               w_unit_ok;
   logic [NUM_DOM-1:0] w_req;
   logic [NUM_DOM-1:0] w_accept;
   logic [NUM_DOM-1:0] w_active;
   logic [NUM_DOM-1:0] w_enter;
   logic [16:0]        w_sum;
   logic [15:0]        r_gate_count;

   assign w_unit_ok  = 32'(op_unit) < NUM_DOM;
   assign op_ready   = |w_accept;
   assign gate_count = r_gate_count;

   for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
      assign w_req[d]    = op_valid && w_unit_ok && (op_unit == UW'(d));
      assign w_accept[d] = w_req[d] && w_active[d] && !reset;
      cg_domain_fsm #(
         .IDLE_CYCLES (IDLE_CYCLES),
         .WAKE_CYCLES (WAKE_CYCLES)
      ) u_fsm (
         .clk           (clk),
         .reset         (reset),
         .i_req         (w_req[d]),
         .i_accept      (w_accept[d]),
         .i_force       (force_on),
         .o_active      (w_active[d]),
         .o_gate_en     (gate_en[d]),
         .o_gated       (gated[d]),
         .o_enter_gated (w_enter[d])
      );
   end

   // Running total plus the number of domains gating at this edge, one bit wider to catch overflow
   always_comb begin
      w_sum = {1'b0, r_gate_count} + 17'($countones(w_enter));
   end

   // Saturating gate-event counter
   always_ff @(posedge clk) begin
      if (reset) r_gate_count <= '0;
      else       r_gate_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
   end

endmodule

// File: tb/tb_clock_gate_controller.sv
// tb_clock_gate_controller: directed scenarios plus randomized traffic against a cycle-count reference model
module tb_clock_gate_controller;

   localparam int ND = 4;
   localparam int IC = 8;
   localparam int WC = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic [1:0]  op_unit = 2'd0;
   logic        force_on = 1'b0;
   logic        op_ready;
   logic [3:0]  gate_en;
   logic [3:0]  gated;
   logic [15:0] gate_count;

   int passed = 0;
   int total  = 0;

   // Reference model: each domain is awake, asleep or waking; waking domains know the cycle they come back
   int cyc = 0;
   int m_mode[ND];
   int m_idle[ND];
   int m_back[ND];
   int m_count = 0;

   always #5 clk = ~clk;

   clock_gate_controller #(.NUM_DOM(ND), .IDLE_CYCLES(IC), .WAKE_CYCLES(WC)) dut (
      .clk        (clk),
      .reset      (reset),
      .op_valid   (op_valid),
      .op_unit    (op_unit),
      .op_ready   (op_ready),
      .force_on   (force_on),
      .gate_en    (gate_en),
      .gated      (gated),
      .gate_count (gate_count)
   );

   function automatic bit m_ready();
      return op_valid && !reset && (m_mode[op_unit] == 0);
   endfunction

   function automatic logic [3:0] m_en();
      logic [3:0] v;
      for (int d = 0; d < ND; d++) v[d] = (m_mode[d] != 1);
      return v;
   endfunction

   task automatic model_edge();
      int gone;
      bit acc;
      gone = 0;
      acc = m_ready();
      for (int d = 0; d < ND; d++) begin
         if (reset) begin
            m_mode[d] = 0;
            m_idle[d] = 0;
         end else if (m_mode[d] == 0) begin
            if ((acc && op_unit == d) || force_on) m_idle[d] = 0;
            else m_idle[d]++;
            if (m_idle[d] == IC) begin
               m_mode[d] = 1;
               gone++;
            end
         end else if (m_mode[d] == 1) begin
            if ((op_valid && op_unit == d) || force_on) begin
               m_mode[d] = 2;
               m_back[d] = cyc + WC + 1;
            end
         end else if (cyc + 1 == m_back[d]) begin
            m_mode[d] = 0;
            m_idle[d] = 0;
         end
      end
      m_count = reset ? 0 : ((m_count + gone > 65535) ? 65535 : m_count + gone);
      cyc++;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      op_valid = 1'b0;
      force_on = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      op_valid = 1'b1;
      op_unit = 2'd0;
      step();
      #1;
      if (op_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", op_ready); else passed++;
      total++;
      step();
      #1;
      if (gate_en !== 4'hF) $display("FAIL reset_gate_en got=%h want=f", gate_en); else passed++;
      total++;
      if (gated !== 4'h0) $display("FAIL reset_gated got=%h want=0", gated); else passed++;
      total++;
      if (gate_count !== 16'h0) $display("FAIL reset_count got=%h want=0", gate_count); else passed++;
      total++;
      reset = 1'b0;
      op_valid = 1'b0;
   endtask

   task automatic test_idle_gate();
      do_reset();
      op_valid = 1'b1;
      op_unit = 2'd0;
      #1;
      if (op_ready !== 1'b1) $display("FAIL idle_accept got=%b want=1", op_ready); else passed++;
      total++;
      step();
      op_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         #1;
         if (gate_en[0] !== (k <= 8)) $display("FAIL idle_gate_en0 cycle=%0d got=%b want=%b", k, gate_en[0], k <= 8); else passed++;
         total++;
         if (gated[0] !== (k >= 9)) $display("FAIL idle_gated0 cycle=%0d got=%b want=%b", k, gated[0], k >= 9); else passed++;
         total++;
         if (gate_count !== 16'(m_count)) $display("FAIL idle_count cycle=%0d got=%0d want=%0d", k, gate_count, m_count); else passed++;
         total++;
         if (k < 10) step();
      end
   endtask

   task automatic test_wake();
      op_valid = 1'b1;
      op_unit = 2'd0;
      for (int i = 0; i <= 3; i++) begin
         #1;
         if (op_ready !== (i == 3)) $display("FAIL wake_ready w+%0d got=%b want=%b", i, op_ready, i == 3); else passed++;
         total++;
         if (gate_en[0] !== (i >= 1)) $display("FAIL wake_gate_en0 w+%0d got=%b want=%b", i, gate_en[0], i >= 1); else passed++;
         total++;
         step();
      end
      op_valid = 1'b0;
   endtask

   task automatic test_mul_stream();
      do_reset();
      op_valid = 1'b1;
      op_unit = 2'd3;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (gate_en[3] !== 1'b1 || op_ready !== 1'b1) $display("FAIL mul_stream cycle=%0d got en3=%b ready=%b want 1/1", i, gate_en[3], op_ready); else passed++;
         total++;
         step();
      end
      #1;
      if (gate_en !== 4'b1000) $display("FAIL mul_gate_en got=%b want=1000", gate_en); else passed++;
      total++;
      if (gate_count !== 16'd3) $display("FAIL mul_count got=%0d want=3", gate_count); else passed++;
      total++;
      op_valid = 1'b0;
   endtask

   task automatic test_force();
      do_reset();
      op_valid = 1'b1;
      op_unit = 2'd0;
      step();
      op_valid = 1'b0;
      for (int i = 1; i < 8; i++) step();
      force_on = 1'b1;
      step();
      force_on = 1'b0;
      #1;
      if (gate_en[0] !== 1'b1 || gated[0] !== 1'b0) $display("FAIL force_block got en0=%b gated0=%b want 1/0", gate_en[0], gated[0]); else passed++;
      total++;
      for (int i = 0; i < 10; i++) step();
      #1;
      if (gated[0] !== 1'b1) $display("FAIL force_regate got=%b want=1", gated[0]); else passed++;
      total++;
      force_on = 1'b1;
      step();
      force_on = 1'b0;
      op_valid = 1'b1;
      op_unit = 2'd0;
      for (int i = 1; i <= 3; i++) begin
         #1;
         if (gate_en[0] !== 1'b1 || op_ready !== (i == 3)) $display("FAIL force_wake g+%0d got en0=%b ready=%b want 1/%b", i, gate_en[0], op_ready, i == 3); else passed++;
         total++;
         step();
      end
      op_valid = 1'b0;
      #1;
      if (gate_count !== 16'(m_count)) $display("FAIL force_count got=%0d want=%0d", gate_count, m_count); else passed++;
      total++;
   endtask

   task automatic test_reset_in_wake();
      do_reset();
      for (int i = 0; i < 10; i++) step();
      op_valid = 1'b1;
      op_unit = 2'd1;
      step();
      #1;
      if (gate_en[1] !== 1'b1 || gated[1] !== 1'b0 || op_ready !== 1'b0) $display("FAIL rwake_in_wake got en1=%b gated1=%b ready=%b want 1/0/0", gate_en[1], gated[1], op_ready); else passed++;
      total++;
      reset = 1'b1;
      op_valid = 1'b0;
      step();
      #1;
      if (gate_en !== 4'hF || gated !== 4'h0 || gate_count !== 16'h0) $display("FAIL rwake_after got en=%h gated=%h count=%0d want f/0/0", gate_en, gated, gate_count); else passed++;
      total++;
      reset = 1'b0;
   endtask

   task automatic test_saturate();
      do_reset();
      op_valid = 1'b1;
      op_unit = 2'd3;
      for (int i = 0; i < 3; i++) step();
      force dut.r_gate_count = 16'hFFFE;
      #1;
      release dut.r_gate_count;
      m_count = 65534;
      for (int i = 3; i < 10; i++) step();
      #1;
      if (gated !== 4'b0111 || gate_count !== 16'hFFFF) $display("FAIL sat_three got gated=%b count=%h want 0111/ffff", gated, gate_count); else passed++;
      total++;
      op_valid = 1'b0;
      for (int i = 0; i < 12; i++) step();
      #1;
      if (gated !== 4'hF || gate_count !== 16'hFFFF) $display("FAIL sat_hold got gated=%b count=%h want 1111/ffff", gated, gate_count); else passed++;
      total++;
   endtask

   task automatic test_random();
      bit pending;
      bit acc;
      do_reset();
      pending = 1'b0;
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         force_on = ($urandom_range(0, 19) == 0);
         if (!pending) begin
            op_valid = ($urandom_range(0, 7) == 0);
            op_unit = 2'($urandom_range(0, 3));
         end
         #1;
         if (op_ready !== m_ready()) $display("FAIL rand_ready i=%0d got=%b want=%b", i, op_ready, m_ready()); else passed++;
         total++;
         if (gate_en !== m_en()) $display("FAIL rand_gate_en i=%0d got=%b want=%b", i, gate_en, m_en()); else passed++;
         total++;
         if (gated !== ~m_en()) $display("FAIL rand_gated i=%0d got=%b want=%b", i, gated, ~m_en()); else passed++;
         total++;
         if (gate_count !== 16'(m_count)) $display("FAIL rand_count i=%0d got=%0d want=%0d", i, gate_count, m_count); else passed++;
         total++;
         acc = m_ready();
         pending = op_valid && !acc && !reset;
         step();
      end
      reset = 1'b0;
      op_valid = 1'b0;
      force_on = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_idle_gate();
      test_wake();
      test_mul_stream();
      test_force();
      test_reset_in_wake();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
